// File: rtl/i2s_receiver_pkg.sv
// Shared constants for the I2S receive path.
`timescale 1ns / 1ps
package i2s_receiver_pkg;

   localparam int unsigned SAMPLE_WIDTH = 24;
   localparam int unsigned SyncDepth    = 2;

   // Counter must hold 0..width+1 so overlong words saturate instead of wrapping.
   function automatic int unsigned bitcnt_width(input int unsigned width);
      return $clog2(width + 2);
   endfunction

endpackage

// File: rtl/i2s_receiver_sync_edge_detect.sv
// Multi-flop synchronizer for the I2S pins plus a rising-edge detector on the bit clock.
`timescale 1ns / 1ps
module sync_edge_detect #(
   parameter int unsigned Depth     = 2,
   parameter int unsigned DataWidth = 2
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 sclk_i,
   input  logic [DataWidth-1:0] data_i,
   output logic                 rise_o,
   output logic [DataWidth-1:0] data_o
);

   localparam int unsigned ChainW = DataWidth + 1;

   // Bit 0 carries sclk; data shares the same depth so all pins stay aligned.
   logic [Depth-1:0][ChainW-1:0] sync_d, sync_q;
   logic                         sclk_prev_d, sclk_prev_q;

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = {data_i, sclk_i};
      for (int i = 1; i < int'(Depth); i++) begin
         sync_d[i] = sync_q[i-1];
      end
      sclk_prev_d = sync_q[Depth-1][0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q      <= '0;
         sclk_prev_q <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         sclk_prev_q <= sclk_prev_d;
      end
   end

   assign rise_o = sync_q[Depth-1][0] & ~sclk_prev_q;
   assign data_o = sync_q[Depth-1][ChainW-1:1];

endmodule

// File: rtl/i2s_receiver.sv
// I2S receiver: oversamples sclk/lrclk/sd with clk, checks word lengths and emits L/R pairs.
`timescale 1ns / 1ps
module i2s_receiver
   import i2s_receiver_pkg::*;
#(
   parameter int unsigned WIDTH = SAMPLE_WIDTH
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    enable,
   input  logic                    sclk,
   input  logic                    lrclk,
   input  logic                    sd,
   output logic signed [WIDTH-1:0] left_data,
   output logic signed [WIDTH-1:0] right_data,
   output logic                    valid,
   output logic                    frame_err
);

   typedef enum logic [1:0] {StSync, StLeft, StRight} state_e;

   localparam int unsigned     CntW    = bitcnt_width(WIDTH);
   localparam logic [CntW-1:0] CntSat  = CntW'(WIDTH + 1);
   localparam logic [CntW-1:0] CntGood = CntW'(WIDTH);

   logic       rise;
   logic       lr;
   logic       sd_s;
   logic [1:0] pins_s;

   sync_edge_detect #(
      .Depth    (SyncDepth),
      .DataWidth(2)
   ) u_sync (
      .clk   (clk),
      .rstn  (rstn),
      .sclk_i(sclk),
      .data_i({lrclk, sd}),
      .rise_o(rise),
      .data_o(pins_s)
   );

   assign lr   = pins_s[1];
   assign sd_s = pins_s[0];

   state_e           state_d, state_q;
   logic [CntW-1:0]  bitcnt_d, bitcnt_q, word_len;
   logic [WIDTH-1:0] shreg_d, shreg_q, word;
   logic [WIDTH-1:0] left_hold_d, left_hold_q;
   logic [WIDTH-1:0] left_data_d, left_data_q, right_data_d, right_data_q;
   logic             lr_prev_d, lr_prev_q;
   logic             have_left_d, have_left_q;
   logic             valid_d, valid_q, frame_err_d, frame_err_q;
   logic             boundary, good;

   always_comb begin
      state_d      = state_q;
      bitcnt_d     = bitcnt_q;
      shreg_d      = shreg_q;
      lr_prev_d    = lr_prev_q;
      have_left_d  = have_left_q;
      left_hold_d  = left_hold_q;
      left_data_d  = left_data_q;
      right_data_d = right_data_q;
      valid_d      = 1'b0;
      frame_err_d  = 1'b0;

      // word/word_len describe the word as it stands including the bit arriving on this rise.
      word     = {shreg_q[WIDTH-2:0], sd_s};
      word_len = (bitcnt_q == CntSat) ? CntSat : bitcnt_q + 1'b1;
      good     = (word_len == CntGood);
      boundary = rise & (lr != lr_prev_q);

      if (rise) begin
         shreg_d   = word;
         bitcnt_d  = boundary ? '0 : word_len;
         lr_prev_d = lr;
      end

      if (!enable) begin
         state_d     = StSync;
         have_left_d = 1'b0;
      end else if (boundary) begin
         unique case (state_q)
            StSync: begin
               state_d     = lr ? StRight : StLeft;
               have_left_d = 1'b0;
            end
            StLeft: begin
               state_d = StRight;
               if (good) begin
                  left_hold_d = word;
                  have_left_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
                  have_left_d = 1'b0;
               end
            end
            StRight: begin
               state_d     = StLeft;
               have_left_d = 1'b0;
               if (!good) begin
                  frame_err_d = 1'b1;
               end else if (have_left_q) begin
                  left_data_d  = left_hold_q;
                  right_data_d = word;
                  valid_d      = 1'b1;
               end
            end
            default: state_d = StSync;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= StSync;
         bitcnt_q     <= '0;
         shreg_q      <= '0;
         lr_prev_q    <= 1'b0;
         have_left_q  <= 1'b0;
         left_hold_q  <= '0;
         left_data_q  <= '0;
         right_data_q <= '0;
         valid_q      <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         bitcnt_q     <= bitcnt_d;
         shreg_q      <= shreg_d;
         lr_prev_q    <= lr_prev_d;
         have_left_q  <= have_left_d;
         left_hold_q  <= left_hold_d;
         left_data_q  <= left_data_d;
         right_data_q <= right_data_d;
         valid_q      <= valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign left_data  = left_data_q;
   assign right_data = right_data_q;
   assign valid      = valid_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Randomized bench for i2s_receiver: a word-level model predicts every valid/frame_err strobe.
`timescale 1ns / 1ps
module tb_i2s_receiver;
   import i2s_receiver_pkg::*;

   localparam int unsigned W = SAMPLE_WIDTH;

   logic         clk, rstn, enable, sclk, lrclk, sd;
   logic [W-1:0] left_data, right_data;
   logic         valid, frame_err;

   i2s_receiver #(
      .WIDTH(W)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .enable    (enable),
      .sclk      (sclk),
      .lrclk     (lrclk),
      .sd        (sd),
      .left_data (left_data),
      .right_data(right_data),
      .valid     (valid),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      bit           is_err;
      logic [W-1:0] l;
      logic [W-1:0] r;
      time          t;
   } ev_t;

   ev_t exp_q[$];

   // Word-level model: stream is segmented into words at each lrclk change.
   logic [63:0]  m_bits;
   int           m_len;
   logic         m_prev;
   bit           m_synced;
   bit           m_pend;
   logic [W-1:0] m_hold;
   int           n_exp_valid = 0;
   int           n_seen_valid = 0;

   task automatic model_clear();
      m_bits = '0; m_len = 0; m_prev = 1'b0; m_synced = 0; m_pend = 0; m_hold = '0;
   endtask

   task automatic push_ev(input bit is_err, input logic [W-1:0] l, input logic [W-1:0] r);
      ev_t e;
      e.is_err = is_err; e.l = l; e.r = r; e.t = $time;
      exp_q.push_back(e);
      if (!is_err) n_exp_valid++;
   endtask

   task automatic model_word(input logic ch, input int len, input logic [W-1:0] value);
      if (!m_synced) begin
         m_synced = 1; m_pend = 0;
      end else if (len != int'(W)) begin
         push_ev(1, '0, '0);
         m_pend = 0;
      end else if (ch == 1'b0) begin
         m_pend = 1; m_hold = value;
      end else if (m_pend) begin
         push_ev(0, m_hold, value);
         m_pend = 0;
      end
   endtask

   task automatic drive_bit(input logic lr, input logic b);
      sclk = 1'b0; lrclk = lr; sd = b;
      #40;
      sclk = 1'b1;
      m_bits = {m_bits[62:0], b};
      m_len++;
      if (lr != m_prev) begin
         model_word(m_prev, m_len, m_bits[W-1:0]);
         m_len  = 0;
         m_prev = lr;
      end
      #40;
   endtask

   task automatic drop_enable();
      sclk = 1'b0;
      #15; enable = 1'b0;
      #50; enable = 1'b1;
      #15;
      m_synced = 0; m_pend = 0;
   endtask

   task automatic pulse_reset();
      check_eq("queue_empty_before_reset", 64'(exp_q.size()), 0);
      sclk = 1'b0;
      #13; rstn = 1'b0;
      #1;
      check_eq("rst_left_data", 64'(left_data), 0);
      check_eq("rst_right_data", 64'(right_data), 0);
      check_eq("rst_valid", 64'(valid), 0);
      check_eq("rst_frame_err", 64'(frame_err), 0);
      #21; rstn = 1'b1;
      #15;
      model_clear();
   endtask

   // The last bit of a word already carries the next channel's lrclk value.
   task automatic emit_word(input logic ch, input int len, input logic [63:0] data,
                            input int drop_at, input int rst_at);
      for (int i = len - 1; i >= 0; i--) begin
         if (i == drop_at) drop_enable();
         if (i == rst_at) pulse_reset();
         drive_bit((i == 0) ? ~ch : ch, data[i]);
      end
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic frame(input logic [63:0] l, input logic [63:0] r);
      emit_word(1'b0, W, l, -1, -1);
      emit_word(1'b1, W, r, -1, -1);
   endtask

   // Strobe monitor: every strobe must match the head of the expected queue.
   logic [W-1:0] cur_l, cur_r;
   always @(negedge clk) begin
      if (!rstn) begin
         cur_l = '0; cur_r = '0;
      end else begin
         check_eq("strobe_exclusive", 64'(valid & frame_err), 0);
         if (valid || frame_err) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_strobe", 64'({valid, frame_err}), 0);
            end else begin
               ev_t e;
               time lat;
               e = exp_q.pop_front();
               lat = $time - e.t;
               check_eq("strobe_kind_is_err", 64'(frame_err), 64'(e.is_err));
               check_eq("strobe_latency_ok", 64'(lat >= 20 && lat <= 50), 1);
               if (!e.is_err) begin
                  n_seen_valid++;
                  check_eq("valid_left", 64'(left_data), 64'(e.l));
                  check_eq("valid_right", 64'(right_data), 64'(e.r));
                  cur_l = e.l; cur_r = e.r;
               end
            end
         end
         check_eq("hold_left", 64'(left_data), 64'(cur_l));
         check_eq("hold_right", 64'(right_data), 64'(cur_r));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] l, r;
      int          ll, rl;
      rstn = 1'b0; enable = 1'b0; sclk = 1'b0; lrclk = 1'b0; sd = 1'b0;
      model_clear();
      #2;
      check_eq("reset_left_data", 64'(left_data), 0);
      check_eq("reset_right_data", 64'(right_data), 0);
      check_eq("reset_valid", 64'(valid), 0);
      check_eq("reset_frame_err", 64'(frame_err), 0);
      #21; rstn = 1'b1; enable = 1'b1;
      #20;

      // Startup mid-right-word, then loopback pattern.
      emit_word(1'b1, 9, rnd64(), -1, -1);
      repeat (3) frame(64'h123456, 64'hFEDCBA);
      frame(rnd64(), rnd64());

      // Short left word, then recovery.
      emit_word(1'b0, W - 1, rnd64(), -1, -1);
      emit_word(1'b1, W, rnd64(), -1, -1);
      frame(rnd64(), rnd64());

      // Overlong right words; 56 bits would alias to 24 in a wrapping 5-bit counter.
      emit_word(1'b0, W, rnd64(), -1, -1);
      emit_word(1'b1, 30, rnd64(), -1, -1);
      frame(rnd64(), rnd64());
      emit_word(1'b0, W, rnd64(), -1, -1);
      emit_word(1'b1, 56, rnd64(), -1, -1);
      frame(rnd64(), rnd64());

      // Enable drop mid-left-word.
      emit_word(1'b0, W, rnd64(), 12, -1);
      emit_word(1'b1, W, rnd64(), -1, -1);
      frame(rnd64(), rnd64());
      frame(rnd64(), rnd64());

      // Asynchronous reset mid-left-word.
      emit_word(1'b0, W, rnd64(), -1, 10);
      emit_word(1'b1, W, rnd64(), -1, -1);
      frame(rnd64(), rnd64());
      frame(rnd64(), rnd64());

      // Random frames with occasional bad lengths.
      for (int k = 0; k < 14; k++) begin
         l  = rnd64();
         r  = rnd64();
         ll = ($urandom_range(3) == 0) ? int'($urandom_range(W + 2, W - 2)) : int'(W);
         rl = ($urandom_range(3) == 0) ? int'($urandom_range(W + 2, W - 2)) : int'(W);
         emit_word(1'b0, ll, l, -1, -1);
         emit_word(1'b1, rl, r, -1, -1);
      end

      #300;
      check_eq("expected_queue_drained", 64'(exp_q.size()), 0);
      check_eq("valid_count", 64'(n_seen_valid), 64'(n_exp_valid));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/i2s_receiver.md
# i2s_receiver

- Serial audio input stage: deserializes an I2S stream (`sclk`, `lrclk`, `sd`) from an external ADC or codec into parallel signed left/right samples in the `clk` domain.
- It is the receive-side counterpart of `dac_transmitter` and uses the same framing: 2 × `SAMPLE_WIDTH` bits per frame, MSB first, one-bit delay after the `lrclk` transition.
- It samples the external bit clock by oversampling with `clk`. It checks the word length of every frame and presents a stereo sample pair with a single-cycle `valid` strobe.

## Interface

Parameters:
- `WIDTH`, default `SAMPLE_WIDTH` (24): bits per channel word.

Ports:
- `clk`, in, 1: system clock (~18.432 MHz); must be ≥ 4× `sclk`.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `enable`, in, 1: receiver enable. When low, forces the SYNC state and suppresses `valid`.
- `sclk`, in, 1: I2S bit clock, asynchronous to `clk`.
- `lrclk`, in, 1: I2S word select, asynchronous to `clk`; 0 = left, 1 = right.
- `sd`, in, 1: I2S serial data, asynchronous to `clk`.
- `left_data`, out, WIDTH, signed: last complete left word.
- `right_data`, out, WIDTH, signed: last complete right word.
- `valid`, out, 1: one-cycle strobe; a new left/right pair is on the outputs.
- `frame_err`, out, 1: one-cycle strobe; a word had a bit count ≠ WIDTH.

## Operation

Input capture:
- `sclk`, `lrclk` and `sd` each pass through a 2-flop synchronizer. All three use identical depth so that they stay aligned.
- A third register on the synchronized `sclk` detects rising edges: `rise = s2 & ~s3`.

Bit capture, on each `rise`:
- Shift the synchronized `sd` into `shreg`, MSB first.
- Increment `bitcnt`, saturating at WIDTH+1.
- Compare the synchronized `lrclk` (`lr`) with `lr_prev`, then set `lr_prev <= lr`.

Word boundary:
- Occurs when `lr != lr_prev` at a `rise`. The bit shifted in on that same `rise` is the LSB of the word belonging to channel `lr_prev`.
- Compare the word's bit count, including that LSB, with WIDTH:
  - Equal to WIDTH: the word is good.
  - Anything else: the word is bad.
- After the comparison, `bitcnt` restarts at 0 for the next word.

States:
- **SYNC** (reset state; also forced whenever `enable` = 0):
  - Bits are shifted and counted but discarded.
  - On the first boundary, go to LEFT if `lr` = 0, else RIGHT. No `frame_err`.
- **LEFT**, boundary ending a left word:
  - Good word: `left_hold <= shreg`, `have_left <= 1`, go to RIGHT.
  - Bad word: pulse `frame_err`, `have_left <= 0`, go to RIGHT.
- **RIGHT**, boundary ending a right word:
  - Good word and `have_left`: `left_data <= left_hold`, `right_data <= shreg`, pulse `valid`, `have_left <= 0`.
  - Good word but no `have_left`: drop the word, no strobe.
  - Bad word: pulse `frame_err`, `have_left <= 0`.
  - In all cases, go to LEFT.

Boundary conditions:
- A right word is never paired with a left word from an earlier frame.
- `enable` falling mid-word: the partial frame is discarded, `have_left <= 0`, and `valid` is not asserted.
- `sclk` stopping: the block holds its state and outputs; there is no timeout.
- More than WIDTH bits in a word: `bitcnt` saturates, and the word is flagged bad at its boundary. No wrap-around.
- `valid` and `frame_err` are never high in the same cycle.

## Timing

- Reset values:
  - `left_data` = 0, `right_data` = 0, `valid` = 0, `frame_err` = 0.
  - State = SYNC; `bitcnt`, `shreg` and `have_left` cleared.
  - `lr_prev` = 0; all synchronizer flops = 0.
- Latency:
  - `valid` / `frame_err` rise 3 `clk` edges after the `sclk` rising edge that carries the boundary LSB, with +1 edge of synchronizer uncertainty.
  - `left_data` and `right_data` update on the same edge that `valid` rises.
- Strobe width: exactly 1 `clk` cycle; at most one strobe per `sclk` period.
- Output holding: outputs hold their values until the next `valid`; `frame_err` does not alter them.
- Throughput: one pair per 2·WIDTH `sclk` periods (48 kHz at `sclk` = 2.304 MHz).

## Structure

- No shared-package addition is needed for the interface.
- `WIDTH` defaults from `SAMPLE_WIDTH` in constants.svh.
- The state enum (SYNC/LEFT/RIGHT) is local to the module.
- Sub-module `sync_edge_detect`: 2-flop synchronizer plus rise-edge register, parameterized on depth. Instantiate it for `sclk`; use its synchronizer path with the same depth for `lrclk` and `sd`.

## Test plan

- **Loopback:** `dac_transmitter` (WIDTH = 24, `sclk` = `clk`/8) sends left = 0x123456, right = 0xFEDCBA → `valid` pulses once per frame, `left_data` = 0x123456, `right_data` = 0xFEDCBA, `frame_err` never high.
- **Startup mid-frame:** stream starts mid-right-word after reset → first partial words are discarded in SYNC, first `valid` occurs after the first complete left+right frame, and the values match.
- **Short word:** left word of 23 bits, then a good right word → one `frame_err` pulse, no `valid` for that frame, next good frame gives `valid` with correct data.
- **Long word:** right word of 30 bits → `frame_err` pulses and `bitcnt` does not wrap; outputs keep the previous pair.
- **Enable drop:** `enable` driven low mid-left-word for 5 cycles → no `valid` for that frame; `valid` resumes on the second complete frame.
- **Async reset:** `rstn` asserted mid-frame, asynchronous to `clk` → all outputs are 0 immediately; after release, first `valid` occurs only after a full new frame.
